// File: rtl/time_counter_24h_pkg.sv
// Alarm-clock digit limits and BCD time helpers shared by the time counter and display stage.
// No logic of its own; latency and backpressure are not applicable.
// Limits are per BCD digit; 24h validity is checked as a whole time.
package time_counter_24h_pkg;

  localparam logic [3:0] MS_MIN_MAX     = 4'd5;
  localparam logic [3:0] LS_MIN_MAX     = 4'd9;
  localparam logic [3:0] MS_HR_MAX      = 4'd2;
  localparam logic [3:0] LS_HR_MAX      = 4'd9;
  localparam logic [3:0] LS_HR_MAX_AT_2 = 4'd3;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  // True when every digit is BCD-in-range and the hour is 00..23.
  function automatic logic bcd_time_valid(input bcd_time_t t);
    return (t.ms_hr  <= MS_HR_MAX)  &&
           (t.ls_hr  <= LS_HR_MAX)  &&
           (t.ms_min <= MS_MIN_MAX) &&
           (t.ls_min <= LS_MIN_MAX) &&
           !((t.ms_hr == MS_HR_MAX) && (t.ls_hr > LS_HR_MAX_AT_2));
  endfunction

endpackage

// File: rtl/time_counter_24h_digit.sv
// Single BCD digit counter 0..MAX with parallel load and carry-out.
// Latency: value updates one cycle after load/inc_en; carry is combinational from value and inc_en.
// Backpressure: none; load wins over inc_en, reset wins over both.
module bcd_digit_counter
  import time_counter_24h_pkg::*;
#(
  parameter logic [3:0] MAX = LS_MIN_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       carry
);

  assign carry = inc_en && (value == MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (inc_en) begin
      value <= (value == MAX) ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/time_counter_24h.sv
// 24-hour BCD time-of-day counter with validated parallel load, day-wrap and load-error pulses.
// Latency: one cycle from one_minute/load_new_c to registered outputs.
// Backpressure: none; load beats tick (tick dropped), reset beats everything.
module time_counter_24h
  import time_counter_24h_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       day_wrap,
  output logic       load_err
);

  bcd_time_t new_time;
  logic      load_ok;
  logic      tick_en;
  logic      ls_min_carry;
  logic      min_carry;
  logic      hour_at_23;

  assign new_time = '{ms_hr:  new_current_time_ms_hr,
                      ls_hr:  new_current_time_ls_hr,
                      ms_min: new_current_time_ms_min,
                      ls_min: new_current_time_ls_min};

  assign load_ok = load_new_c && bcd_time_valid(new_time);
  // A tick coinciding with any load request is dropped, even if the load is rejected.
  assign tick_en = one_minute && !load_new_c;

  bcd_digit_counter #(.MAX(LS_MIN_MAX)) u_ls_min (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (tick_en),
    .load     (load_ok),
    .load_val (new_current_time_ls_min),
    .value    (current_time_ls_min),
    .carry    (ls_min_carry)
  );

  bcd_digit_counter #(.MAX(MS_MIN_MAX)) u_ms_min (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (ls_min_carry),
    .load     (load_ok),
    .load_val (new_current_time_ms_min),
    .value    (current_time_ms_min),
    .carry    (min_carry)
  );

  assign hour_at_23 = (current_time_ms_hr == MS_HR_MAX) &&
                      (current_time_ls_hr == LS_HR_MAX_AT_2);

  always_ff @(posedge clk) begin
    if (reset) begin
      current_time_ms_hr <= 4'd0;
      current_time_ls_hr <= 4'd0;
    end else if (load_ok) begin
      current_time_ms_hr <= new_current_time_ms_hr;
      current_time_ls_hr <= new_current_time_ls_hr;
    end else if (min_carry) begin
      if (hour_at_23) begin
        current_time_ms_hr <= 4'd0;
        current_time_ls_hr <= 4'd0;
      end else if (current_time_ls_hr == LS_HR_MAX) begin
        current_time_ms_hr <= current_time_ms_hr + 4'd1;
        current_time_ls_hr <= 4'd0;
      end else begin
        current_time_ls_hr <= current_time_ls_hr + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      day_wrap <= min_carry && hour_at_23;
      load_err <= load_new_c && !load_ok;
    end
  end

endmodule

// File: tb/tb_time_counter_24h.sv
// Directed vector table plus hand-written sequences for held loads and a full-day soak.
module tb_time_counter_24h;

  logic       clk = 1'b0;
  logic       reset, one_minute, load_new_c;
  logic [3:0] n_mh, n_lh, n_mm, n_lm;
  logic [3:0] c_mh, c_lh, c_mm, c_lm;
  logic       day_wrap, load_err;

  int n_checks = 0;
  int n_fail   = 0;

  time_counter_24h dut (
    .clk                     (clk),
    .reset                   (reset),
    .one_minute              (one_minute),
    .load_new_c              (load_new_c),
    .new_current_time_ms_hr  (n_mh),
    .new_current_time_ls_hr  (n_lh),
    .new_current_time_ms_min (n_mm),
    .new_current_time_ls_min (n_lm),
    .current_time_ms_hr      (c_mh),
    .current_time_ls_hr      (c_lh),
    .current_time_ms_min     (c_mm),
    .current_time_ls_min     (c_lm),
    .day_wrap                (day_wrap),
    .load_err                (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        tick;
    logic        ld;
    logic [15:0] nt;
    logic [15:0] et;
    logic        ew;
    logic        ee;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic t, input logic l, input logic [15:0] nt,
                     input logic [15:0] et, input logic ew, input logic ee);
    vec_t v;
    v.rst = r; v.tick = t; v.ld = l; v.nt = nt; v.et = et; v.ew = ew; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic t, input logic l, input logic [15:0] nt);
    @(negedge clk);
    reset = r; one_minute = t; load_new_c = l;
    n_mh = nt[15:12]; n_lh = nt[11:8]; n_mm = nt[7:4]; n_lm = nt[3:0];
  endtask

  task automatic check(input string nm, input logic [15:0] et, input logic ew, input logic ee);
    logic [15:0] got;
    got = {c_mh, c_lh, c_mm, c_lm};
    n_checks++;
    if (got !== et || day_wrap !== ew || load_err !== ee) begin
      n_fail++;
      $display("FAIL %s: got time=%h day_wrap=%b load_err=%b, expected time=%h day_wrap=%b load_err=%b",
               nm, got, day_wrap, load_err, et, ew, ee);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic t, input logic l,
                      input logic [15:0] nt, input logic [15:0] et, input logic ew, input logic ee);
    drive(r, t, l, nt);
    @(posedge clk);
    #1;
    check(nm, et, ew, ee);
  endtask

  function automatic logic [15:0] to_bcd(input int m);
    int h, mi;
    logic [15:0] e;
    h  = m / 60;
    mi = m % 60;
    e[15:12] = 4'(h / 10);
    e[11:8]  = 4'(h % 10);
    e[7:4]   = 4'(mi / 10);
    e[3:0]   = 4'(mi % 10);
    return e;
  endfunction

  initial begin
    int m;
    int wraps;
    int range_bad;
    logic [15:0] cur;

    reset = 1'b1; one_minute = 1'b0; load_new_c = 1'b0;
    n_mh = 4'd0; n_lh = 4'd0; n_mm = 4'd0; n_lm = 4'd0;

    //   rst  tick ld   new       expected  wrap err
    add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0); // reset state
    add(1'b0, 1'b0, 1'b1, 16'h1437, 16'h1437, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1438, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'h1111, 16'h0000, 1'b0, 1'b0); // reset beats load and tick
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h0959, 16'h0959, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h1959, 16'h1959, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h2000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); // day wrap
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h0730, 16'h0730, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h2400, 16'h0730, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h1260, 16'h0730, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 16'h2A00, 16'h0730, 1'b0, 1'b1); // rejected load still eats the tick
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0730, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h0815, 16'h0815, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'h1111, 16'h1111, 1'b0, 1'b0); // collision
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1112, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1113, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1113, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0); // reset at 23:59
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h2000, 16'h2000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h2340, 16'h2340, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h3000, 16'h2340, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].tick, vecs[i].ld, vecs[i].nt,
           vecs[i].et, vecs[i].ew, vecs[i].ee);
    end

    // load_new_c held high: each cycle evaluated on its own.
    step("held_bad0", 1'b0, 1'b0, 1'b1, 16'h2500, 16'h2340, 1'b0, 1'b1);
    step("held_bad1", 1'b0, 1'b0, 1'b1, 16'h2500, 16'h2340, 1'b0, 1'b1);
    step("held_good", 1'b0, 1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0);
    step("held_good2", 1'b0, 1'b1, 1'b1, 16'h1235, 16'h1235, 1'b0, 1'b0);
    step("held_bad2", 1'b0, 1'b0, 1'b1, 16'h1299, 16'h1235, 1'b0, 1'b1);
    step("held_rel", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1235, 1'b0, 1'b0);

    // Full-day soak against an integer minute model.
    step("soak_rst", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    m = 0; wraps = 0; range_bad = 0;
    for (int k = 0; k < 1440; k++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0000);
      @(posedge clk);
      #1;
      m = (m + 1) % 1440;
      if (day_wrap === 1'b1) wraps++;
      cur = {c_mh, c_lh, c_mm, c_lm};
      if (c_lm > 4'd9 || c_mm > 4'd5 || c_lh > 4'd9 || c_mh > 4'd2 ||
          (c_mh == 4'd2 && c_lh > 4'd3) || (day_wrap === 1'b1 && load_err === 1'b1))
        range_bad++;
      if (cur !== to_bcd(m) || day_wrap !== (m == 0) || load_err !== 1'b0)
        check($sformatf("soak%0d", k), to_bcd(m), (m == 0), 1'b0);
    end
    n_checks++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL soak_wraps: got %0d day_wrap pulses, expected 1", wraps);
    end
    n_checks++;
    if (range_bad != 0) begin
      n_fail++;
      $display("FAIL soak_range: got %0d out-of-range cycles, expected 0", range_bad);
    end
    step("soak_end", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_counter_24h.md
TIME_COUNTER_24H -- requirements
Module: time_counter_24h

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port one_minute, input, 1 bit: one-cycle tick, one per elapsed minute.
REQ-004 SHALL have port load_new_c, input, 1 bit: request to load the new current time.
REQ-005 SHALL have ports new_current_time_ms_hr, new_current_time_ls_hr, new_current_time_ms_min and new_current_time_ls_min, each input, 4 bits: BCD digits of the time to load.
REQ-006 SHALL have ports current_time_ms_hr, current_time_ls_hr, current_time_ms_min and current_time_ls_min, each output, 4 bits: registered BCD current time, consumed by the display stage.
REQ-007 SHALL have port day_wrap, output, 1 bit: one-cycle pulse when the time rolls from 23:59 to 00:00.
REQ-008 SHALL have port load_err, output, 1 bit: one-cycle pulse when a load request is rejected as invalid.

Function
REQ-009 SHALL hold all four time digits in registers; outputs driven directly from registers, no combinational path from inputs.
REQ-010 SHALL give load_new_c priority over one_minute when both are high in the same cycle; that tick is discarded, not deferred.
REQ-011 SHALL accept a load only if valid: ms_hr<=2, ls_hr<=9, ms_min<=5, ls_min<=9, and hour<=23 (ms_hr=2 requires ls_hr<=3).
REQ-012 SHALL, on a valid load, update all four digits at the next rising edge (1-cycle latency); load_err stays 0.
REQ-013 SHALL, on an invalid load, keep the time unchanged and pulse load_err high for exactly one cycle.
REQ-014 SHALL, with load_new_c held high, evaluate each cycle independently: one update or one load_err pulse per cycle.
REQ-015 SHALL, on one_minute with no load, increment the time by one minute in BCD.
REQ-016 SHALL apply these increment rules: ls_min 0-9 with carry at 9->0; ms_min 0-5 with carry at 5->0; the minute carry advances the hour.
REQ-017 SHALL advance the hour as follows: ls_hr 0-9 with carry at 9->0 into ms_hr; at 23, the minute carry gives 00.
REQ-018 SHALL, at 23:59 on one_minute, go to 00:00 and assert day_wrap for exactly that one cycle.
REQ-019 SHALL hold all digits when neither one_minute nor load_new_c is asserted.
REQ-020 SHALL never produce a non-BCD or out-of-range digit from counting; day_wrap and load_err are never high in the same cycle.
REQ-021 SHALL treat one_minute high on consecutive cycles as one increment per cycle; no edge detection.

Reset
REQ-022 SHALL, on reset high at a clock edge, set every current_time digit to 0 (00:00) and drive day_wrap=0 and load_err=0.
REQ-023 SHALL give reset priority over load_new_c and one_minute, including mid-load and at 23:59.
REQ-024 SHALL, on the first edge after reset deasserts, resume normal behaviour; no tick is remembered across reset.

Structure
REQ-025 SHALL take digit limits from a shared alarm-clock constants package: MS_MIN_MAX=5, LS_MIN_MAX=9, MS_HR_MAX=2, LS_HR_MAX=9, LS_HR_MAX_AT_2=3; the display stage reuses these.
REQ-026 SHALL build the minute digits from one sub-module, bcd_digit_counter, instantiated twice.
REQ-027 SHALL give bcd_digit_counter: a parameterised max, inc_en input, load input, reset, value output and carry output.
REQ-028 SHALL implement the hour pair as a dedicated 00-23 counter in the top module, plus the load validation and the pulse outputs.

Verification
REQ-029 SHALL cover reset: reset during counting at 14:37 -> next edge gives 00:00, day_wrap=0, load_err=0.
REQ-030 SHALL cover carries: load 09:59, then one_minute -> 10:00; load 19:59, then one_minute -> 20:00.
REQ-031 SHALL cover day wrap: load 23:59, then one_minute -> 00:00 with day_wrap=1 for one cycle, then 0.
REQ-032 SHALL cover invalid loads: 24:00, 12:60 and 2A:00 -> time unchanged and load_err pulses once per request cycle.
REQ-033 SHALL cover collision: at 08:15, load_new_c with 11:11 and one_minute in the same cycle -> 11:11, not 11:12, and not 08:16.
REQ-034 SHALL cover a full-day soak: 1440 one_minute ticks from 00:00 -> back to 00:00 with exactly one day_wrap, and every digit in range throughout.
